// File: rtl/stage1_lmn_if.sv
// Leg-vector request and L/M/N result bundle for one servo's stage-1 IK block.
// The master drives the strobe and the leg vector; the slave returns the terms and a valid pulse.
interface stage1_lmn_if;
    logic               enable;
    logic signed [8:0]  lx;
    logic signed [8:0]  ly;
    logic        [7:0]  lz;
    logic        [15:0] L;
    logic        [13:0] M;
    logic signed [14:0] N;
    logic               valid;

    modport master (
        output enable, lx, ly, lz,
        input  L, M, N, valid
    );

    modport slave (
        input  enable, lx, ly, lz,
        output L, M, N, valid
    );
endinterface

// File: rtl/stage1_lmn.sv
// Stage 1 of the per-servo IK pipeline: from one leg vector, forms the L, M, N terms of
// alpha = asin(L/sqrt(M^2+N^2)) - atan(N/M) through a four-state multicycle datapath.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for enable; captures lx/ly/lz when it arrives
//   MUL   | squares of the captured vector and the cos/sin products
//   SUM   | sum of squares, trig sum, M term
//   DONE  | clamps L, scales/shifts N, loads outputs and pulses valid
module stage1_lmn #(
    parameter int BETA  = 330,
    parameter int ARM_A = 16,
    parameter int LEG_S = 120
) (
    input  logic         clock,
    input  logic         rst,
    stage1_lmn_if.slave  bus
);

    function automatic int cos_q14(input int deg);
        case (deg)
            0:       return 16384;
            30:      return 14189;
            60:      return 8192;
            90:      return 0;
            120:     return -8192;
            150:     return -14189;
            180:     return -16384;
            210:     return -14189;
            240:     return -8192;
            270:     return 0;
            300:     return 8192;
            330:     return 14189;
            default: return 0;
        endcase
    endfunction

    function automatic int sin_q14(input int deg);
        case (deg)
            0:       return 0;
            30:      return 8192;
            60:      return 14189;
            90:      return 16384;
            120:     return 14189;
            150:     return 8192;
            180:     return 0;
            210:     return -8192;
            240:     return -14189;
            270:     return -16384;
            300:     return -14189;
            330:     return -8192;
            default: return 0;
        endcase
    endfunction

    localparam logic signed [15:0] COS_Q = 16'(cos_q14(BETA));
    localparam logic signed [15:0] SIN_Q = 16'(sin_q14(BETA));
    localparam logic signed [19:0] LEG_K = 20'(LEG_S * LEG_S - ARM_A * ARM_A);
    localparam logic signed [7:0]  TWO_A = 8'(2 * ARM_A);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] SUM  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;

    logic signed [8:0]  cap_x;
    logic signed [8:0]  cap_y;
    logic        [7:0]  cap_z;

    logic        [16:0] sq_x;
    logic        [16:0] sq_y;
    logic        [15:0] sq_z;
    logic signed [24:0] prod_c;
    logic signed [24:0] prod_s;

    logic        [17:0] sum_sq;
    logic signed [25:0] trig_sum;
    logic        [13:0] m_term;

    logic signed [17:0] sqx_full;
    logic signed [17:0] sqy_full;
    logic        [15:0] sqz_full;
    logic signed [24:0] pc_full;
    logic signed [24:0] ps_full;

    logic signed [19:0] l_diff;
    logic        [15:0] l_next;
    logic signed [33:0] n_full;
    logic signed [14:0] n_next;

    // Operands are widened before multiplying so the products never wrap.
    assign sqx_full = 18'(cap_x) * 18'(cap_x);
    assign sqy_full = 18'(cap_y) * 18'(cap_y);
    assign sqz_full = 16'(cap_z) * 16'(cap_z);
    assign pc_full  = 25'(COS_Q) * 25'(cap_x);
    assign ps_full  = 25'(SIN_Q) * 25'(cap_y);

    always_comb begin
        l_diff = $signed({2'b00, sum_sq}) - LEG_K;
        l_next = l_diff[15:0];
        if (l_diff < 20'sd0) begin
            l_next = 16'd0;
        end else if (l_diff > 20'sd65535) begin
            l_next = 16'hFFFF;
        end
    end

    // Arithmetic shift floors toward -inf, which is the rounding the later stages expect.
    always_comb begin
        n_full = 34'(trig_sum) * 34'(TWO_A);
        n_next = 15'(n_full >>> 14);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            bus.L     <= 16'd0;
            bus.M     <= 14'd0;
            bus.N     <= 15'sd0;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    state <= SUM;
                end
                SUM: begin
                    state <= DONE;
                end
                DONE: begin
                    bus.L     <= l_next;
                    bus.M     <= m_term;
                    bus.N     <= n_next;
                    bus.valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; nothing reaches the outputs except through DONE.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.enable) begin
            cap_x <= bus.lx;
            cap_y <= bus.ly;
            cap_z <= bus.lz;
        end
        if (state == MUL) begin
            sq_x   <= sqx_full[16:0];
            sq_y   <= sqy_full[16:0];
            sq_z   <= sqz_full;
            prod_c <= pc_full;
            prod_s <= ps_full;
        end
        if (state == SUM) begin
            sum_sq   <= 18'(sq_x) + 18'(sq_y) + 18'(sq_z);
            trig_sum <= 26'(prod_c) + 26'(prod_s);
            m_term   <= 14'(cap_z) * 14'(TWO_A);
        end
    end

endmodule

// File: tb/tb_stage1_lmn.sv
// Randomized and directed bench for stage1_lmn: a BETA=330 and a BETA=90 instance checked
// against an arithmetic model of the L/M/N equations, including latency, pulse width and reset abort.
module tb_stage1_lmn;

    localparam int ARM_A = 16;
    localparam int LEG_S = 120;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    stage1_lmn_if bus_a ();
    stage1_lmn_if bus_b ();

    stage1_lmn #(.BETA(330), .ARM_A(ARM_A), .LEG_S(LEG_S)) dut_a (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_a)
    );

    stage1_lmn #(.BETA(90), .ARM_A(ARM_A), .LEG_S(LEG_S)) dut_b (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_b)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer evaluation of the L, M, N definitions.
    task automatic model(input int c, input int s, input int x, input int y, input int z,
                         output longint el, output longint em, output longint en);
        longint sumsq, d, num, q;
        sumsq = longint'(x) * x + longint'(y) * y + longint'(z) * z;
        d     = sumsq - (LEG_S * LEG_S - ARM_A * ARM_A);
        el    = (d < 0) ? 0 : ((d > 65535) ? 65535 : d);
        em    = 2 * ARM_A * z;
        num   = 2 * ARM_A * (longint'(c) * x + longint'(s) * y);
        q     = num / 16384;
        if ((num % 16384) != 0 && num < 0) q = q - 1;
        en    = q;
    endtask

    task automatic drive(input bit which, input bit en, input int x, input int y, input int z);
        if (which) begin
            bus_b.enable = en; bus_b.lx = 9'(x); bus_b.ly = 9'(y); bus_b.lz = 8'(z);
        end else begin
            bus_a.enable = en; bus_a.lx = 9'(x); bus_a.ly = 9'(y); bus_a.lz = 8'(z);
        end
    endtask

    task automatic sample(input bit which, output longint l, output longint m,
                          output longint n, output bit v);
        if (which) begin
            l = bus_b.L; m = bus_b.M; n = bus_b.N; v = bus_b.valid;
        end else begin
            l = bus_a.L; m = bus_a.M; n = bus_a.N; v = bus_a.valid;
        end
    endtask

    function automatic int rnd_s9();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // mode 0: single strobe; mode 1: strobe held and inputs scrambled during MUL/SUM
    task automatic run_vec(input bit which, input int x, input int y, input int z,
                           input int mode, input string tag);
        longint el, em, en, gl, gm, gn;
        bit     gv;
        int     k, pulses, c, s;
        c = which ? 0 : 14189;
        s = which ? 16384 : -8192;
        model(c, s, x, y, z, el, em, en);
        @(negedge clock);
        drive(which, 1'b1, x, y, z);
        @(negedge clock);
        drive(which, mode == 1, rnd_s9(), rnd_s9(), int'($urandom_range(0, 255)));
        k = 0;
        sample(which, gl, gm, gn, gv);
        while (!gv && k < 8) begin
            if (k == 2) drive(which, 1'b0, rnd_s9(), rnd_s9(), int'($urandom_range(0, 255)));
            @(negedge clock);
            k++;
            sample(which, gl, gm, gn, gv);
        end
        check_val({tag, "_lat"}, k, 3);
        check_val({tag, "_L"}, gl, el);
        check_val({tag, "_M"}, gm, em);
        check_val({tag, "_N"}, gn, en);
        pulses = 0;
        repeat ((mode == 1) ? 6 : 1) begin
            @(negedge clock);
            sample(which, gl, gm, gn, gv);
            pulses += int'(gv);
        end
        check_val({tag, "_extra_pulse"}, pulses, 0);
        check_val({tag, "_hold_L"}, gl, el);
    endtask

    task automatic reset_in_sum();
        longint gl, gm, gn;
        bit     gv;
        int     pulses;
        @(negedge clock);
        drive(1'b0, 1'b1, 50, -60, 200);
        @(negedge clock);
        drive(1'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        sample(1'b0, gl, gm, gn, gv);
        check_val("rst_sum_L", gl, 0);
        check_val("rst_sum_M", gm, 0);
        check_val("rst_sum_N", gn, 0);
        pulses = int'(gv);
        repeat (6) begin
            @(negedge clock);
            sample(1'b0, gl, gm, gn, gv);
            pulses += int'(gv);
        end
        check_val("rst_sum_no_valid", pulses, 0);
    endtask

    task automatic held_enable(input int x, input int y, input int z);
        longint el, em, en, gl, gm, gn;
        bit     gv;
        int     cnt, first, last, bad_val;
        model(14189, -8192, x, y, z, el, em, en);
        cnt = 0; first = -1; last = -1; bad_val = 0;
        @(negedge clock);
        drive(1'b0, 1'b1, x, y, z);
        @(negedge clock);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 11) drive(1'b0, 1'b0, x, y, z);
            sample(1'b0, gl, gm, gn, gv);
            if (gv) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
                if (gl != el || gm != em || gn != en) bad_val++;
            end
        end
        check_val("held_count", cnt, 3);
        check_val("held_first", first, 3);
        check_val("held_last", last, 11);
        check_val("held_values", bad_val, 0);
    endtask

    initial begin
        longint gl, gm, gn;
        bit     gv;
        drive(1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clock);
        for (int w = 0; w < 2; w++) begin
            sample(w[0], gl, gm, gn, gv);
            check_val("reset_L", gl, 0);
            check_val("reset_M", gm, 0);
            check_val("reset_N", gn, 0);
            check_val("reset_valid", longint'(gv), 0);
        end
        rst = 1'b0;

        run_vec(1'b0, -24, 26, 117, 0, "basic");
        run_vec(1'b0, 0, 0, 0, 0, "zero_clamp");
        run_vec(1'b0, -256, -256, 255, 0, "neg_sat");
        run_vec(1'b0, 255, 255, 255, 0, "pos_sat");
        run_vec(1'b1, 10, 20, 50, 0, "beta90");
        run_vec(1'b0, 100, -50, 30, 1, "ignore_busy");
        reset_in_sum();
        run_vec(1'b0, -24, 26, 117, 0, "after_rst");
        held_enable(37, -101, 90);

        for (int i = 0; i < 40; i++) begin
            run_vec(i[0], rnd_s9(), rnd_s9(), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
